// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
//   fetch_entry_t : one prefetch-queue entry {pc_next, instr} at the
//                   default 32-bit address / 32-bit instruction widths.
//   count_width() : width of an occupancy counter that must hold 0..depth.
package fetch_pkg;

    localparam int ENTRY_ADDR_W  = 32;
    localparam int ENTRY_INSTR_W = 32;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0]  pc_next;
        logic [ENTRY_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO holding prefetched instruction entries.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers/count only)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry
//   clear      : empty the queue; wins over push in the same cycle
//   head       : entry at the read pointer (meaningful when count != 0)
//   count      : number of valid entries, 0..DEPTH
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ENTRY_W-1:0]            push_data,
    input  logic                          pop,
    input  logic                          clear,
    output logic [ENTRY_W-1:0]            head,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit_pq.sv
// Instruction-fetch stage with a prefetch queue.
// Issues sequential reads to a synchronous instruction memory, buffers the
// returned words with their next-PC, and presents them to decode over a
// valid/ready handshake. A taken branch flushes queued and in-flight words
// and issues the target in the same cycle.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   branch_taken/branch_addr : redirect request and target from execute
//   id_ready                 : decode accepts the head entry this cycle
//   imem_en/imem_addr        : memory read strobe and address
//   imem_rdata               : read data, one cycle after imem_en
//   if_valid/if_instr/if_pc  : head entry to decode (if_pc = address + PC_INC)
//   flush                    : pipeline flush, mirrors branch_taken
module fetch_unit_pq
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               id_ready,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               flush
);

    localparam int                CNT_W   = count_width(DEPTH);
    localparam int                ENTRY_W = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] INC     = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] push_data;
    logic [CNT_W:0]     occupancy;
    logic               push;
    logic               pop;
    logic               room;
    logic               issue;

    always_comb begin
        if_valid  = (count != '0) && !branch_taken;
        pop       = if_valid && id_ready;
        // A response arriving during a redirect belongs to the old stream.
        push      = inflight && !branch_taken;
        // Occupancy after this edge; the new request lands one cycle later,
        // so it may only issue if a slot will still be free.
        occupancy = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
        room      = occupancy < (CNT_W + 1)'(DEPTH);
        issue     = branch_taken || room;
        imem_addr = branch_taken ? branch_addr : fetch_pc;
        // Reset only gates the strobe seen by the memory; state flops are
        // already held by the asynchronous reset.
        imem_en   = issue && !rst;
        flush     = branch_taken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) fetch_pc <= imem_addr + INC;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) inflight_pc <= imem_addr;
    end

    assign push_data = {inflight_pc + INC, imem_rdata};

    fetch_queue #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (branch_taken),
        .head      (head),
        .count     (count)
    );

    assign if_pc    = head[ENTRY_W-1:INSTR_W];
    assign if_instr = head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit_pq.sv
// Self-checking bench for fetch_unit_pq (DEPTH=4, RESET_PC=0, PC_INC=4).
// A reference model tracks the list of issued-but-not-consumed addresses:
// decode must see them in issue order, two cycles after issue, and the
// list may never exceed DEPTH words.
module tb_fetch_unit_pq;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        id_ready = 1'b0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;

    fetch_unit_pq #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .PC_INC   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .id_ready     (id_ready),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    logic [31:0] salt = 32'h1234_5678;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Synchronous memory; garbage on idle cycles so stray pushes are visible.
    always @(posedge clk) imem_rdata <= imem_en ? mem_word(imem_addr) : $urandom;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } issue_t;

    issue_t      model_q[$];
    logic [31:0] exp_issue;
    int          cyc;
    int          checks = 0;
    int          failures = 0;

    logic        o_en, o_valid, o_flush;
    logic [31:0] o_addr, o_pc, o_instr;

    task automatic model_reset();
        model_q.delete();
        exp_issue = RESET_PC;
        cyc = 0;
    endtask

    // One clock cycle: drive, sample at negedge, score against the model.
    task automatic tick(input logic br, input logic [31:0] ba, input logic rdy);
        logic         exp_valid;
        logic         exp_en;
        fetch_entry_t e;
        issue_t       it;
        branch_taken = br;
        branch_addr  = ba;
        id_ready     = rdy;
        @(negedge clk);
        o_en = imem_en; o_addr = imem_addr; o_valid = if_valid;
        o_pc = if_pc; o_instr = if_instr; o_flush = flush;

        exp_valid = 1'b0;
        if (!br && model_q.size() > 0) exp_valid = (model_q[0].cyc <= cyc - 2);

        checks++;
        if (o_flush !== br) begin
            failures++;
            $display("FAIL flush cyc=%0d got=%b want=%b", cyc, o_flush, br);
        end
        checks++;
        if (o_valid !== exp_valid) begin
            failures++;
            $display("FAIL if_valid cyc=%0d got=%b want=%b", cyc, o_valid, exp_valid);
        end
        if (exp_valid && rdy) begin
            e.pc_next = model_q[0].addr + 32'd4;
            e.instr   = mem_word(model_q[0].addr);
            checks++;
            if (o_pc !== e.pc_next || o_instr !== e.instr) begin
                failures++;
                $display("FAIL head cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                         cyc, o_pc, o_instr, e.pc_next, e.instr);
            end
            void'(model_q.pop_front());
        end

        if (br) begin
            model_q.delete();
            exp_issue = ba;
            exp_en = 1'b1;
        end else begin
            exp_en = (model_q.size() < DEPTH);
        end
        checks++;
        if (o_en !== exp_en) begin
            failures++;
            $display("FAIL imem_en cyc=%0d got=%b want=%b", cyc, o_en, exp_en);
        end
        if (exp_en) begin
            checks++;
            if (o_addr !== exp_issue) begin
                failures++;
                $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, o_addr, exp_issue);
            end
            it.addr = exp_issue;
            it.cyc  = cyc;
            model_q.push_back(it);
            exp_issue = exp_issue + 32'd4;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        branch_taken = 1'b0;
        id_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_en !== 1'b0 || if_valid !== 1'b0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got en=%b valid=%b flush=%b want 0 0 0", imem_en, if_valid, flush);
        end
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        #1;
        checks++;
        if (flush !== 1'b1 || imem_en !== 1'b0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_branch got flush=%b en=%b valid=%b want 1 0 0", flush, imem_en, if_valid);
        end
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (imem_en !== 1'b0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_held got en=%b valid=%b want 0 0", imem_en, if_valid);
        end
        rst = 1'b0;
        model_reset();
        tick(1'b0, '0, 1'b1);
        checks++;
        if (o_en !== 1'b1 || o_addr !== RESET_PC) begin
            failures++;
            $display("FAIL first_issue got en=%b addr=%h want 1 %h", o_en, o_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        for (int t = 0; t < 16; t++) begin
            tick(1'b0, '0, 1'b1);
            checks++;
            if (o_en !== 1'b1 || o_addr !== 32'(4 * t)) begin
                failures++;
                $display("FAIL stream_issue t=%0d got en=%b addr=%h want 1 %h", t, o_en, o_addr, 32'(4 * t));
            end
            if (t >= 2) begin
                checks++;
                if (o_valid !== 1'b1 || o_pc !== 32'(4 * (t - 1))) begin
                    failures++;
                    $display("FAIL stream_head t=%0d got valid=%b pc=%h want 1 %h", t, o_valid, o_pc, 32'(4 * (t - 1)));
                end
            end
        end
    endtask

    task automatic test_freeze();
        int n;
        apply_reset();
        n = 0;
        for (int t = 0; t < 10; t++) begin
            tick(1'b0, '0, 1'b0);
            if (o_en === 1'b1) n++;
        end
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL freeze_issues got=%0d want=%0d", n, DEPTH);
        end
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h4) begin
            failures++;
            $display("FAIL freeze_hold got valid=%b pc=%h want 1 00000004", o_valid, o_pc);
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, '0, 1'b1);
            checks++;
            if (o_valid !== 1'b1 || o_pc !== 32'(4 * (k + 1))) begin
                failures++;
                $display("FAIL freeze_release k=%0d got valid=%b pc=%h want 1 %h", k, o_valid, o_pc, 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_branch();
        apply_reset();
        // After four frozen cycles: three entries queued, one in flight.
        for (int t = 0; t < 4; t++) tick(1'b0, '0, 1'b0);
        tick(1'b1, 32'h100, 1'b0);
        checks++;
        if (o_flush !== 1'b1 || o_valid !== 1'b0 || o_en !== 1'b1 || o_addr !== 32'h100) begin
            failures++;
            $display("FAIL branch_cycle got flush=%b valid=%b en=%b addr=%h want 1 0 1 00000100",
                     o_flush, o_valid, o_en, o_addr);
        end
        tick(1'b0, '0, 1'b1);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL branch_gap got valid=%b want 0", o_valid);
        end
        tick(1'b0, '0, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h104) begin
            failures++;
            $display("FAIL branch_target got valid=%b pc=%h want 1 00000104", o_valid, o_pc);
        end
        for (int t = 0; t < 8; t++) tick(1'b0, '0, 1'b1);
    endtask

    task automatic test_branch_full();
        apply_reset();
        for (int t = 0; t < 8; t++) tick(1'b0, '0, 1'b0);
        tick(1'b1, 32'h300, 1'b0);
        checks++;
        if (o_en !== 1'b1 || o_addr !== 32'h300) begin
            failures++;
            $display("FAIL branch_full_issue got en=%b addr=%h want 1 00000300", o_en, o_addr);
        end
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h304) begin
            failures++;
            $display("FAIL branch_full_target got valid=%b pc=%h want 1 00000304", o_valid, o_pc);
        end
        for (int t = 0; t < 6; t++) tick(1'b0, '0, 1'b1);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int t = 0; t < 3; t++) tick(1'b0, '0, 1'b1);
        tick(1'b1, 32'h40, 1'b1);
        tick(1'b1, 32'h80, 1'b1);
        tick(1'b0, '0, 1'b1);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap got valid=%b want 0", o_valid);
        end
        tick(1'b0, '0, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h84) begin
            failures++;
            $display("FAIL b2b_first got valid=%b pc=%h want 1 00000084", o_valid, o_pc);
        end
        for (int t = 0; t < 4; t++) tick(1'b0, '0, 1'b1);
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [3];
        logic [31:0] exp_pc   [3];
        exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0;
        exp_pc[0]   = 32'hFFFF_FFFC; exp_pc[1]   = 32'h0;         exp_pc[2]   = 32'h4;
        apply_reset();
        for (int t = 0; t < 2; t++) tick(1'b0, '0, 1'b1);
        for (int t = 0; t < 5; t++) begin
            tick((t == 0), 32'hFFFF_FFF8, 1'b1);
            if (t < 3) begin
                checks++;
                if (o_en !== 1'b1 || o_addr !== exp_addr[t]) begin
                    failures++;
                    $display("FAIL wrap_issue t=%0d got en=%b addr=%h want 1 %h", t, o_en, o_addr, exp_addr[t]);
                end
            end
            if (t >= 2) begin
                checks++;
                if (o_valid !== 1'b1 || o_pc !== exp_pc[t - 2]) begin
                    failures++;
                    $display("FAIL wrap_head t=%0d got valid=%b pc=%h want 1 %h", t, o_valid, o_pc, exp_pc[t - 2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int t = 0; t < 3; t++) tick(1'b0, '0, 1'b1);
        for (int t = 0; t < 3; t++) tick(1'b0, '0, 1'b0);
        checks++;
        if (if_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got valid=%b want 1", if_valid);
        end
        id_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_en !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear got valid=%b en=%b want 0 0", if_valid, imem_en);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick(1'b0, '0, 1'b1);
        checks++;
        if (o_en !== 1'b1 || o_addr !== RESET_PC) begin
            failures++;
            $display("FAIL midrst_restart got en=%b addr=%h want 1 %h", o_en, o_addr, RESET_PC);
        end
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== RESET_PC + 32'd4) begin
            failures++;
            $display("FAIL midrst_head got valid=%b pc=%h want 1 %h", o_valid, o_pc, RESET_PC + 32'd4);
        end
    endtask

    task automatic test_random();
        logic        br, rdy;
        logic [31:0] ba;
        int          freeze;
        apply_reset();
        freeze = 0;
        for (int t = 0; t < 3000; t++) begin
            br = ($urandom_range(0, 19) == 0);
            ba = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & ~32'h3);
            if (freeze > 0) freeze--;
            else if ($urandom_range(0, 49) == 0) freeze = $urandom_range(3, 12);
            rdy = (freeze == 0) && ($urandom_range(0, 3) != 0);
            tick(br, ba, rdy);
        end
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_stream();
        test_freeze();
        test_branch();
        test_branch_full();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
